// File: rtl/sta_sched_pkg.sv
// Shared types and helpers for the systolic tensor array tile scheduler.
// Optional feature macro used by the top: STA_SCHED_PERF_CNT_EN.
package sta_sched_pkg;

  localparam int unsigned DEFAULT_SA_N         = 4;
  localparam int unsigned DEFAULT_VECTOR_WIDTH = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoadBias,
    StFeed,
    StDrain,
    StNext,
    StDone
  } sched_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  function automatic int unsigned tile_count(input int unsigned mat_n, input int unsigned sa_n);
    int unsigned side;
    side = ceil_div(mat_n, sa_n);
    return side * side;
  endfunction

endpackage

// File: rtl/sta_tile_iter.sv
// Row-major tile base-coordinate stepper with last-tile detection.
module sta_tile_iter #(
  parameter int unsigned SA_N = 4,
  parameter int unsigned CW   = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step,
  input  logic          clear,
  input  logic [CW-1:0] mat_size,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic [CW-1:0] row_q, col_q;
  logic [CW:0]   row_nx, col_nx, mat_ext;

  // One extra bit so base + SA_N never wraps at MAX_N.
  assign mat_ext = {1'b0, mat_size};
  assign col_nx  = {1'b0, col_q} + (CW+1)'(SA_N);
  assign row_nx  = {1'b0, row_q} + (CW+1)'(SA_N);
  assign last    = (col_nx >= mat_ext) && (row_nx >= mat_ext);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else if (clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (step) begin
      if (col_nx < mat_ext) begin
        col_q <= col_nx[CW-1:0];
      end else begin
        col_q <= '0;
        row_q <= row_nx[CW-1:0];
      end
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/sta_tile_scheduler.sv
// Sequences one matrix operation on the systolic array tile by tile.
// Define STA_SCHED_PERF_CNT_EN to add active/stall performance counters.
module sta_tile_scheduler
  import sta_sched_pkg::*;
#(
  parameter int unsigned MAX_N        = 512,
  parameter int unsigned MAX_K        = 1024,
  parameter int unsigned SA_N         = DEFAULT_SA_N,
  parameter int unsigned VECTOR_WIDTH = DEFAULT_VECTOR_WIDTH,
  parameter int unsigned DRAIN_CYCLES = 10,
  parameter int unsigned CW           = $clog2(MAX_N + 1),
  parameter int unsigned KW           = $clog2(MAX_K + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          start,
  input  logic [CW-1:0] mat_size,
  input  logic [KW-1:0] k_depth,
  output logic          busy,
  output logic          done,
  output logic          tile_valid,
  output logic [CW-1:0] tile_row,
  output logic [CW-1:0] tile_col,
  output logic          load_bias,
  output logic          feed_en,
  output logic [KW-1:0] feed_k_base,
  output logic          feed_last
`ifdef STA_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]   perf_active_cycles,
  output logic [31:0]   perf_stall_cycles
`endif
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] mat_q, mat_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW:0]   c_q, c_d;
  logic [KW:0]   chunk_q, chunk_d;
  logic [KW-1:0] k_base_q, k_base_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          iter_step, iter_clear, iter_last;
  logic          last_chunk;
  logic          accept;

  assign last_chunk = (chunk_q == c_q - (KW+1)'(1));
  assign accept     = !stall && (state_q == StIdle) && start;

  sta_tile_iter #(
    .SA_N(SA_N),
    .CW  (CW)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .step    (iter_step),
    .clear   (iter_clear),
    .mat_size(mat_q),
    .row     (tile_row),
    .col     (tile_col),
    .last    (iter_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mat_q    <= '0;
      k_q      <= '0;
      c_q      <= '0;
      chunk_q  <= '0;
      k_base_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      k_q      <= k_d;
      c_q      <= c_d;
      chunk_q  <= chunk_d;
      k_base_q <= k_base_d;
      drain_q  <= drain_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mat_d      = mat_q;
    k_d        = k_q;
    c_d        = c_q;
    chunk_d    = chunk_q;
    k_base_d   = k_base_q;
    drain_d    = drain_q;
    iter_step  = 1'b0;
    iter_clear = 1'b0;
    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mat_d      = mat_size;
            k_d        = k_depth;
            iter_clear = 1'b1;
            state_d    = (mat_size == '0 || k_depth == '0) ? StDone : StLoadBias;
          end
        end
        StLoadBias: begin
          k_base_d = '0;
          chunk_d  = '0;
          c_d      = (KW+1)'(ceil_div(32'(k_q), VECTOR_WIDTH));
          state_d  = StFeed;
        end
        StFeed: begin
          if (last_chunk) begin
            drain_d = DW'(DRAIN_CYCLES);
            state_d = StDrain;
          end else begin
            chunk_d  = chunk_q + (KW+1)'(1);
            k_base_d = k_base_q + KW'(VECTOR_WIDTH);
          end
        end
        StDrain: begin
          if (drain_q <= DW'(1)) state_d = StNext;
          else                   drain_d = drain_q - DW'(1);
        end
        StNext: begin
          iter_step = 1'b1;
          state_d   = iter_last ? StDone : StLoadBias;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Strobes decode from the held state, so a stalled strobe reappears once stall drops.
  assign busy        = (state_q != StIdle);
  assign tile_valid  = !stall && (state_q == StLoadBias);
  assign load_bias   = !stall && (state_q == StLoadBias);
  assign feed_en     = !stall && (state_q == StFeed);
  assign feed_last   = !stall && (state_q == StFeed) && last_chunk;
  assign done        = !stall && (state_q == StDone);
  assign feed_k_base = k_base_q;

`ifdef STA_SCHED_PERF_CNT_EN
  logic [31:0] act_q, stl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q <= '0;
      stl_q <= '0;
    end else if (accept) begin
      act_q <= '0;
      stl_q <= '0;
    end else if (busy) begin
      if (stall) begin
        if (stl_q != '1) stl_q <= stl_q + 32'd1;
      end else begin
        if (act_q != '1) act_q <= act_q + 32'd1;
      end
    end
  end

  assign perf_active_cycles = act_q;
  assign perf_stall_cycles  = stl_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// Scoreboard bench for sta_tile_scheduler: stimulus queues expected events, monitor checks them.
module tb_sta_tile_scheduler;

  localparam int SA   = 4;
  localparam int VW   = 4;
  localparam int DRN  = 10;
  localparam int CW   = 10;
  localparam int KW   = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] mat_size = '0;
  logic [KW-1:0] k_depth = '0;
  logic          busy, done, tile_valid, load_bias, feed_en, feed_last;
  logic [CW-1:0] tile_row, tile_col;
  logic [KW-1:0] feed_k_base;
`ifdef STA_SCHED_PERF_CNT_EN
  logic [31:0]   perf_active_cycles, perf_stall_cycles;
`endif

  sta_tile_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .start      (start),
    .mat_size   (mat_size),
    .k_depth    (k_depth),
    .busy       (busy),
    .done       (done),
    .tile_valid (tile_valid),
    .tile_row   (tile_row),
    .tile_col   (tile_col),
    .load_bias  (load_bias),
    .feed_en    (feed_en),
    .feed_k_base(feed_k_base),
    .feed_last  (feed_last)
`ifdef STA_SCHED_PERF_CNT_EN
    ,
    .perf_active_cycles(perf_active_cycles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // kind: 0 tile(a=row,b=col), 1 feed(a=k_base,b=last), 2 done; eff = unstalled cycle index
  typedef struct {
    int kind;
    int a;
    int b;
    int eff;
  } ev_t;

  ev_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  eff = 0;
  int  accept_cyc = 0;
  int  stall_busy = 0;
  int  done_cnt = 0;
  int  done_rel = 0;
  int  done_stalls = 0;
  bit  prev_done = 1'b0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int period(input int m, input int k);
    return (k + VW - 1) / VW + DRN + 2;
  endfunction

  function automatic int exp_done(input int m, input int k);
    int side;
    if (m == 0 || k == 0) return 1;
    side = (m + SA - 1) / SA;
    return 1 + side * side * period(m, k);
  endfunction

  // Reference schedule: every tile row-major, its chunks, then completion.
  function automatic void push_op(input int m, input int k);
    int side, c, p, t;
    if (m == 0 || k == 0) begin
      sb.push_back('{2, 0, 0, 1});
      return;
    end
    side = (m + SA - 1) / SA;
    c    = (k + VW - 1) / VW;
    p    = period(m, k);
    for (int r = 0; r < side; r++) begin
      for (int cc = 0; cc < side; cc++) begin
        t = r * side + cc;
        sb.push_back('{0, r * SA, cc * SA, 1 + t * p});
        for (int j = 0; j < c; j++) sb.push_back('{1, j * VW, (j == c - 1) ? 1 : 0, 2 + t * p + j});
      end
    end
    sb.push_back('{2, 0, 0, exp_done(m, k)});
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (prev_done) chk("busy_after_done", busy, 0);
      if (tile_valid || load_bias) chk("load_bias_eq_tile_valid", load_bias, tile_valid);
      if (feed_last && !feed_en) chk("feed_last_without_feed_en", 1, 0);
      if (stall && (tile_valid || load_bias || feed_en || done))
        chk("strobe_during_stall", 1, 0);
      if (tile_valid || feed_en || done) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          if (tile_valid) begin
            chk("tile_kind", 0, e.kind);
            chk("tile_row", tile_row, e.a);
            chk("tile_col", tile_col, e.b);
          end else if (feed_en) begin
            chk("feed_kind", 1, e.kind);
            chk("feed_k_base", feed_k_base, e.a);
            chk("feed_last", feed_last, e.b);
          end else begin
            chk("done_kind", 2, e.kind);
          end
          chk("event_cycle", eff, e.eff);
        end
      end
      if (busy && stall) stall_busy++;
      if (done) begin
        done_cnt++;
        done_rel    = cyc - accept_cyc;
        done_stalls = stall_busy;
      end
      prev_done = done;
      if (!busy && start && !stall) begin
        eff        = 1;
        accept_cyc = cyc;
        stall_busy = 0;
      end else if (!stall) begin
        eff++;
      end
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    stall = 1'b0;
    start = 1'b0;
    #1;
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // mode 0: no stall, 1: random stall, 2: stall cycles 3..5 after start
  task automatic run_op(input int m, input int k, input int mode, input bit poke);
    int  d0;
    bit  got;
    push_op(m, k);
    d0  = done_cnt;
    got = 1'b0;
    @(posedge clk);
    #1;
    mat_size = CW'(m);
    k_depth  = KW'(k);
    stall    = 1'b0;
    start    = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
      start = poke ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (mode == 1) stall = ($urandom_range(0, 99) < 25);
      else           stall = (mode == 2) && (i >= 3) && (i <= 5);
      if (mode == 2 && i >= 3 && i <= 5) begin
        #1;
        chk("stall_feed_en_low", feed_en, 0);
        chk("stall_k_base_hold", feed_k_base, 4);
      end
    end
    start = 1'b0;
    stall = 1'b0;
    if (!got) begin
      chk("done_timeout", 0, 1);
      apply_reset();
    end else begin
      chk("done_cycle", done_rel, exp_done(m, k) + done_stalls);
      if (mode == 2) chk("stall_done_delay", done_rel, exp_done(m, k) + 3);
      chk("scoreboard_empty", sb.size(), 0);
`ifdef STA_SCHED_PERF_CNT_EN
      chk("perf_active", perf_active_cycles, exp_done(m, k));
      chk("perf_stall", perf_stall_cycles, done_stalls);
`endif
    end
  endtask

  initial begin
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tile_valid", tile_valid, 0);
    chk("reset_feed_en", feed_en, 0);
    chk("reset_k_base", feed_k_base, 0);
    chk("reset_row_col", {tile_row, tile_col}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(8, 8, 0, 1'b0);
    run_op(6, 5, 0, 1'b0);
    run_op(0, 5, 0, 1'b0);
    run_op(8, 0, 0, 1'b0);
    run_op(8, 8, 2, 1'b0);
    run_op(8, 8, 0, 1'b1);
    run_op(1, 1, 0, 1'b0);

    // Abort in the drain window of the second tile.
    push_op(8, 8);
    @(posedge clk);
    #1;
    mat_size = CW'(8);
    k_depth  = KW'(8);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #3;
    chk("pre_reset_col", tile_col, 4);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_strobes", {tile_valid, load_bias, feed_en, feed_last}, 0);
    chk("abort_row_col", {tile_row, tile_col}, 0);
    chk("abort_k_base", feed_k_base, 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    run_op(8, 8, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      run_op($urandom_range(0, 13), $urandom_range(0, 14), 1, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
